seg7_bcd_scanner: RTL
=====================

// Module: seg7_bcd_scanner
// PURPOSE
//   Downstream display stage of the calculator: takes the 14-bit binary value selected
//   for display, converts it to 4 BCD digits with a sequential shift-add-3 (double-dabble)
//   engine and time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
//   Values above 9999 are shown as "----".
// PARAMETERS
//   REFRESH_OVERFLOW  2**19-1  refresh counter terminal count; digit advances every REFRESH_OVERFLOW+1 clk
// PORTS
//   clk            in   1   system clock; all state on rising edge
//   reset          in   1   asynchronous, active-low reset (0 = reset)
//   to_display_nr  in   14  unsigned binary value to display
//   digit_select   out  4   digit anodes, active-low one-hot; bit0 = rightmost (units) digit
//   led_select     out  7   segments {g,f,e,d,c,b,a}, active-low
//   conv_busy      out  1   1 while BCD conversion is in progress
// BEHAVIOUR
//   Reset (async assert, sync release): refresh cnt=0, digit idx=0, BCD regs=0000, FSM=IDLE,
//     start_pending=1. Outputs: digit_select=4'b1110, led_select=7'b1000000 ("0"), conv_busy=0.
//   Refresh: counter width $clog2(REFRESH_OVERFLOW+1); at count==REFRESH_OVERFLOW -> 0 and
//     idx <= idx+1 (2-bit, wraps 3->0). Counter and scan never stall, including during conversion.
//   Converter FSM:
//     IDLE : if start_pending or to_display_nr != last_val -> latch value into shift reg and
//            last_val, clear start_pending, clear BCD scratch, step=0, go SHIFT.
//     SHIFT: per cycle add 3 to each scratch nibble >=5, then shift {scratch,shift} left 1;
//            14 cycles (step 0..13), then go COMMIT.
//     COMMIT: if latched value >9999 set overrange=1, else copy scratch to display BCD regs
//            and overrange=0; go IDLE.
//   conv_busy=1 in SHIFT and COMMIT. Latency input change -> new digits visible: 16 clk.
//   Input changes during SHIFT/COMMIT are ignored; re-compared in IDLE after COMMIT, so the
//     final stable value is always displayed. Display BCD regs change only in COMMIT (no tearing).
//   Decode: digit_select = ~(4'b0001 << idx); led_select = seg(BCD[idx]) combinationally from
//     registered idx/BCD. Codes 0-9 standard; overrange -> every digit 7'b0111111 (g only).
//   Reset mid-conversion aborts; restarts conversion of current input after release.
// CONFIGURATION
//   LEADING_ZERO_BLANK_EN defined: thousands/hundreds/tens digits that are zero and have
//     only zeros to their left show 7'b1111111 (blank); units always shown; overrange unaffected.
//     Reset value of led_select unchanged (units digit selected -> "0").
//   Not defined: all four digits always shown, leading zeros displayed as "0".
// TESTING (REFRESH_OVERFLOW=3 -> digit period 4 clk)
//   1. Reset low 3 clk, release, to_display_nr=0 -> digit_select 1110/1101/1011/0111 every
//      4 clk, led_select=7'b1000000 on each; conv_busy high 16 clk after release then low.
//   2. to_display_nr=1234 -> 16 clk later: units 7'b0011001 (4), tens 7'b0110000 (3),
//      hundreds 7'b0100100 (2), thousands 7'b1111001 (1).
//   3. to_display_nr=9999 then 10000 -> 9 on all digits (7'b0010000), then all 7'b0111111.
//   4. Change 1234->5678 at conversion cycle 5 -> 1234 held; after first conversion ends, second
//      starts, 5678 displayed 16 clk after its start; no intermediate values ever shown.
//   5. Assert reset during SHIFT -> outputs immediately digit_select=1110, led_select=1000000;
//      after release the held input (e.g. 42) is reconverted and displayed.
//   6. LEADING_ZERO_BLANK_EN, value 7 -> thousands/hundreds/tens 7'b1111111, units 7'b1111000;
//      value 0 -> units "0", others blank; value 1005 -> all four digits lit ("1005").

Source files
------------

// File: rtl/seg7_bcd_scanner_if.sv
// rtl/seg7_bcd_scanner_if.sv - display-stage bundle: value to show plus scan/segment drive and busy flag
interface seg7_bcd_scanner_if;
  logic [13:0] to_display_nr;
  logic [3:0]  digit_select;
  logic [6:0]  led_select;
  logic        conv_busy;

  modport master (
    output to_display_nr,
    input  digit_select,
    input  led_select,
    input  conv_busy
  );

  modport slave (
    input  to_display_nr,
    output digit_select,
    output led_select,
    output conv_busy
  );
endinterface

// File: rtl/seg7_bcd_scanner.sv
// rtl/seg7_bcd_scanner.sv - sequential double-dabble BCD converter driving a 4-digit multiplexed 7-seg display
// Optional leading-zero blanking is enabled with `define LEADING_ZERO_BLANK_EN.
module seg7_bcd_scanner #(
  parameter int unsigned REFRESH_OVERFLOW = 2**19 - 1
) (
  input logic              clk,
  input logic              reset,
  seg7_bcd_scanner_if.slave bus
);

  localparam int CNT_W = $clog2(REFRESH_OVERFLOW + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;

  state_t      state_q;
  logic        start_pending_q;
  logic [13:0] last_val_q;
  logic [13:0] shift_q;
  logic [15:0] scratch_q;
  logic [15:0] scratch_d;
  logic [3:0]  step_q;
  logic [15:0] bcd_q;
  logic        overrange_q;
  logic        busy_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
    end else if (cnt_q == CNT_W'(REFRESH_OVERFLOW)) begin
      cnt_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Add-3 correction applied before each shift so every nibble stays a valid BCD digit.
  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      start_pending_q <= 1'b1;
      last_val_q      <= '0;
      shift_q         <= '0;
      scratch_q       <= '0;
      step_q          <= '0;
      bcd_q           <= '0;
      overrange_q     <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_pending_q || (bus.to_display_nr != last_val_q)) begin
            shift_q         <= bus.to_display_nr;
            last_val_q      <= bus.to_display_nr;
            start_pending_q <= 1'b0;
            scratch_q       <= '0;
            step_q          <= '0;
            busy_q          <= 1'b1;
            state_q         <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_q, shift_q} <= {scratch_d[14:0], shift_q, 1'b0};
          step_q               <= step_q + 4'd1;
          if (step_q == 4'd13) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          // Display registers only ever see a finished result, so digits never tear.
          if (last_val_q > 14'd9999) begin
            overrange_q <= 1'b1;
          end else begin
            bcd_q       <= scratch_q;
            overrange_q <= 1'b0;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  logic [3:0] cur_digit;
  logic       blank;

  always_comb begin
    cur_digit = bcd_q[{idx_q, 2'b00} +: 4];
    blank     = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_q != 2'd0) && ((bcd_q >> {idx_q, 2'b00}) == 16'd0);
`endif
    bus.led_select = 7'b1111111;
    if (overrange_q) begin
      bus.led_select = 7'b0111111;
    end else if (!blank) begin
      case (cur_digit)
        4'd0:    bus.led_select = 7'b1000000;
        4'd1:    bus.led_select = 7'b1111001;
        4'd2:    bus.led_select = 7'b0100100;
        4'd3:    bus.led_select = 7'b0110000;
        4'd4:    bus.led_select = 7'b0011001;
        4'd5:    bus.led_select = 7'b0010010;
        4'd6:    bus.led_select = 7'b0000010;
        4'd7:    bus.led_select = 7'b1111000;
        4'd8:    bus.led_select = 7'b0000000;
        4'd9:    bus.led_select = 7'b0010000;
        default: bus.led_select = 7'b1111111;
      endcase
    end
  end

  assign bus.digit_select = ~(4'b0001 << idx_q);
  assign bus.conv_busy    = busy_q;

endmodule
